// File: rtl/imul_pkg.sv
// Shared types and defaults for the iterative multiplier slice.
// No logic here; widths and encodings only.
// Imported by the interface, the core and the top level.
package imul_pkg;

   localparam int N_DEF       = 64;
   localparam int ZR_ADDR_DEF = 31;

   typedef enum logic [1:0] {
      IMUL_MUL   = 2'b00,
      IMUL_UMULH = 2'b01,
      IMUL_SMULH = 2'b10,
      IMUL_RSV   = 2'b11
   } imul_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_WB   = 2'b10
   } imul_state_t;

endpackage

// File: rtl/imul_wb_if.sv
// Control/operand request bundle plus regfile write port of the multiplier.
// No latency of its own; pure wiring.
// start is only honoured while the multiplier is accepting (IDLE or WB).
interface imul_wb_if
   import imul_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int ADDR_W = 5
);
   logic              start;
   imul_op_t          op;
   logic [N-1:0]      a;
   logic [N-1:0]      b;
   logic [ADDR_W-1:0] dst;
   logic              busy;
   logic              done;
   logic              we3;
   logic [ADDR_W-1:0] wa3;
   logic [N-1:0]      wd3;

   modport master (output start, op, a, b, dst,
                   input  busy, done, we3, wa3, wd3);
   modport slave  (input  start, op, a, b, dst,
                   output busy, done, we3, wa3, wd3);
endinterface

// File: rtl/imul_core.sv
// Radix-2 shift-add datapath: operand magnitudes, 2N-bit accumulator, step counter, sign fix.
// N steps after load; product reflects the value after the current step (valid when step && last).
// No backpressure; the controlling FSM decides when to load and step.
module imul_core
   import imul_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic           sgn,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           last,
   output logic [2*N-1:0] product
);
   localparam int CW = $clog2(N);

   logic [N-1:0]   mag_a;
   logic [N-1:0]   mag_b;
   logic           neg;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] acc_nxt;
   logic [N:0]     sum;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;

   // Magnitudes for the signed case; -2^(N-1) maps to 2^(N-1) as an unsigned N-bit value.
   always_comb begin
      a_mag = (sgn && a[N-1]) ? -a : a;
      b_mag = (sgn && b[N-1]) ? -b : b;
   end

   // One step: add multiplicand into the high half if the current multiplier bit is set, then shift right.
   always_comb begin
      sum     = {1'b0, acc[2*N-1:N]} + (mag_b[0] ? {1'b0, mag_a} : {(N+1){1'b0}});
      acc_nxt = {sum, acc[N-1:1]};
      product = neg ? -acc_nxt : acc_nxt;
      last    = (cnt == CW'(N-1));
   end

   // Operand capture on load, accumulate/shift on each step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mag_a <= '0;
         mag_b <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
      end else if (load) begin
         mag_a <= a_mag;
         mag_b <= b_mag;
         neg   <= sgn && (a[N-1] ^ b[N-1]);
         cnt   <= '0;
         acc   <= '0;
      end else if (step) begin
         mag_b <= mag_b >> 1;
         acc   <= acc_nxt;
         cnt   <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/imul_wb.sv
// Iterative MUL/UMULH/SMULH unit writing its result straight into the regfile write port.
// Capture edge E0, steps on E1..EN, one WB cycle after EN with done and the regfile write.
// One multiply in flight; start ignored while busy, accepted in IDLE or back-to-back in WB.
module imul_wb
   import imul_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int ADDR_W  = 5,
   parameter int ZR_ADDR = ZR_ADDR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   imul_wb_if.slave    bus
);
   imul_state_t       state;
   imul_op_t          op_q;
   logic [ADDR_W-1:0] dst_q;
   logic              busy_q;
   logic              done_q;
   logic              we3_q;
   logic [ADDR_W-1:0] wa3_q;
   logic [N-1:0]      wd3_q;

   logic              accept;
   logic              step;
   logic              last;
   logic [2*N-1:0]    product;
   logic [N-1:0]      result;

   assign accept = ((state == S_IDLE) || (state == S_WB)) && bus.start;
   assign step   = (state == S_BUSY);

   imul_core #(.N(N)) u_core (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .step    (step),
      .sgn     (bus.op == IMUL_SMULH),
      .a       (bus.a),
      .b       (bus.b),
      .last    (last),
      .product (product)
   );

   // High half for the MULH variants; MUL and the reserved code take the low half.
   always_comb begin
      result = product[N-1:0];
      if ((op_q == IMUL_UMULH) || (op_q == IMUL_SMULH))
         result = product[2*N-1:N];
   end

   // Control FSM with registered handshake and writeback outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         op_q   <= IMUL_MUL;
         dst_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         we3_q  <= 1'b0;
         wa3_q  <= '0;
         wd3_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  dst_q  <= bus.dst;
                  busy_q <= 1'b1;
                  state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (last) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  we3_q  <= (dst_q != ADDR_W'(ZR_ADDR));
                  wa3_q  <= dst_q;
                  wd3_q  <= result;
                  state  <= S_WB;
               end
            end
            S_WB: begin
               done_q <= 1'b0;
               we3_q  <= 1'b0;
               wa3_q  <= '0;
               wd3_q  <= '0;
               if (bus.start) begin
                  op_q   <= bus.op;
                  dst_q  <= bus.dst;
                  busy_q <= 1'b1;
                  state  <= S_BUSY;
               end else begin
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.we3  = we3_q;
   assign bus.wa3  = wa3_q;
   assign bus.wd3  = wd3_q;
endmodule

// File: tb/tb_imul_wb.sv
// Randomised and directed bench for imul_wb against a wide-arithmetic reference model.
// Each multiply is checked for latency, writeback fields and quiet outputs outside WB.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_imul_wb;
   import imul_pkg::*;

   localparam int N  = 64;
   localparam int AW = 5;
   localparam int ZR = 31;

   logic clk;
   logic reset;
   int   cyc;
   int   t0;
   int   n_chk;
   int   n_pass;

   imul_wb_if #(.N(N), .ADDR_W(AW)) bus ();

   imul_wb #(.N(N), .ADDR_W(AW), .ZR_ADDR(ZR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] ref_result(imul_op_t op, logic [63:0] a, logic [63:0] b);
      logic [127:0]        up;
      logic signed [127:0] sp;
      up = {64'd0, a} * {64'd0, b};
      sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      case (op)
         IMUL_UMULH: return up[127:64];
         IMUL_SMULH: return sp[127:64];
         default:    return up[63:0];
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request, let the capture edge take it, then scramble inputs.
   task automatic start_op(input imul_op_t op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] dst);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.dst   = dst;
      tick();
      t0        = cyc;
      bus.start = 1'b0;
      bus.op    = imul_op_t'($urandom_range(0, 3));
      bus.a     = {$urandom, $urandom};
      bus.b     = {$urandom, $urandom};
      bus.dst   = 5'($urandom_range(0, 31));
      chk("busy_after_capture", 64'(bus.busy), 64'd1);
   endtask

   // Wait for done (bounded), check latency and the writeback; leaves the bench in the WB cycle.
   task automatic finish_op(input string tag, input imul_op_t op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] dst);
      logic stray;
      stray = 1'b0;
      while (!bus.done && (cyc - t0) < N + 8) begin
         tick();
         if (!bus.done && (bus.we3 || bus.wd3 != 64'd0 || bus.wa3 != 5'd0)) stray = 1'b1;
      end
      chk({tag, "_latency"}, 64'(cyc - t0), 64'(N));
      chk({tag, "_stray"},   64'(stray), 64'd0);
      chk({tag, "_busy_wb"}, 64'(bus.busy), 64'd0);
      chk({tag, "_we3"},     64'(bus.we3), 64'(dst != 5'(ZR)));
      chk({tag, "_wa3"},     64'(bus.wa3), 64'(dst));
      chk({tag, "_wd3"},     bus.wd3, ref_result(op, a, b));
   endtask

   task automatic idle_check(input string tag);
      tick();
      chk({tag, "_done_off"}, 64'(bus.done), 64'd0);
      chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
      chk({tag, "_we3_off"},  64'(bus.we3), 64'd0);
      chk({tag, "_wd3_off"},  bus.wd3, 64'd0);
   endtask

   task automatic run_op(input string tag, input imul_op_t op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] dst);
      start_op(op, a, b, dst);
      finish_op(tag, op, a, b, dst);
      idle_check(tag);
   endtask

   initial begin
      logic        quiet;
      logic [63:0] ra;
      logic [63:0] rb;
      imul_op_t    rop;
      logic [63:0] specials [4];
      n_chk     = 0;
      n_pass    = 0;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = IMUL_MUL;
      bus.a     = '0;
      bus.b     = '0;
      bus.dst   = '0;
      specials[0] = 64'h0;
      specials[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      specials[2] = 64'h8000_0000_0000_0000;
      specials[3] = 64'h7FFF_FFFF_FFFF_FFFF;

      repeat (3) tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_we3",  64'(bus.we3), 64'd0);
      chk("rst_wa3",  64'(bus.wa3), 64'd0);
      chk("rst_wd3",  bus.wd3, 64'd0);
      reset = 1'b1;
      tick();

      run_op("mul_3x5",  IMUL_MUL,   64'd3, 64'd5, 5'd4);
      run_op("umulh_ff", IMUL_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7);
      run_op("mul_ff",   IMUL_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8);
      run_op("smulh_m1", IMUL_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9);
      run_op("smulh_min", IMUL_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd10);
      run_op("rsv_as_mul", IMUL_RSV, 64'd123456789, 64'd987654321, 5'd11);
      run_op("mul_zr",   IMUL_MUL,   64'd7, 64'd9, 5'd31);

      // start pulsed mid-BUSY is ignored; start in WB is taken back-to-back.
      start_op(IMUL_MUL, 64'd6, 64'd7, 5'd12);
      repeat (10) tick();
      bus.start = 1'b1;
      bus.a     = 64'd1;
      bus.b     = 64'd1;
      bus.dst   = 5'd13;
      repeat (5) tick();
      bus.start = 1'b0;
      finish_op("ignored_mid", IMUL_MUL, 64'd6, 64'd7, 5'd12);
      start_op(IMUL_UMULH, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 5'd14);
      finish_op("b2b", IMUL_UMULH, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 5'd14);
      idle_check("b2b");

      // Asynchronous reset mid-operation.
      start_op(IMUL_MUL, 64'd11, 64'd13, 5'd15);
      repeat (29) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_we3",  64'(bus.we3), 64'd0);
      chk("arst_wa3",  64'(bus.wa3), 64'd0);
      chk("arst_wd3",  bus.wd3, 64'd0);
      tick();
      @(negedge clk);
      reset = 1'b1;
      quiet = 1'b1;
      repeat (N + 5) begin
         tick();
         if (bus.we3 || bus.done || bus.busy) quiet = 1'b0;
      end
      chk("arst_no_wb", 64'(quiet), 64'd1);
      run_op("post_rst", IMUL_MUL, 64'd2, 64'd2, 5'd3);

      // Randomised operations with some corner operands mixed in.
      for (int i = 0; i < 24; i++) begin
         rop = imul_op_t'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : {$urandom, $urandom};
         rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : {$urandom, $urandom};
         start_op(rop, ra, rb, 5'($urandom_range(0, 31)));
         finish_op($sformatf("rnd%0d", i), rop, ra, rb, dut.dst_q);
         idle_check($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
